// File: rtl/multi_device_valve_sequencer_pkg.sv
// Shared definitions for the multi-device valve sequencer.
// Holds the command op encoding, the controller state encoding and the
// pump phase pattern tables used by the top-level sequencer.
package multi_device_valve_sequencer_pkg;

    // Command op encoding carried on cmd_op
    localparam logic [1:0] OP_SET    = 2'd0;
    localparam logic [1:0] OP_PUMP_A = 2'd1;
    localparam logic [1:0] OP_PUMP_B = 2'd2;
    localparam logic [1:0] OP_FLUSH  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SET_DWELL = 3'd1,
        ST_PUMP_A    = 3'd2,
        ST_PUMP_B    = 3'd3,
        ST_FLUSH     = 3'd4
    } seq_state_t;

    // Index of the last phase in one full pump cycle
    localparam logic [2:0] PUMP_A_LAST = 3'd5;
    localparam logic [2:0] PUMP_B_LAST = 3'd3;

    // 3-valve peristaltic pattern: 100,110,010,011,001,101
    function automatic logic [2:0] pump_a_pattern(input logic [2:0] idx);
        case (idx)
            3'd0:    pump_a_pattern = 3'b100;
            3'd1:    pump_a_pattern = 3'b110;
            3'd2:    pump_a_pattern = 3'b010;
            3'd3:    pump_a_pattern = 3'b011;
            3'd4:    pump_a_pattern = 3'b001;
            3'd5:    pump_a_pattern = 3'b101;
            default: pump_a_pattern = 3'b000;
        endcase
    endfunction

    // 2-valve pattern: 10,11,01,00
    function automatic logic [1:0] pump_b_pattern(input logic [2:0] idx);
        case (idx)
            3'd0:    pump_b_pattern = 2'b10;
            3'd1:    pump_b_pattern = 2'b11;
            3'd2:    pump_b_pattern = 2'b01;
            3'd3:    pump_b_pattern = 2'b00;
            default: pump_b_pattern = 2'b00;
        endcase
    endfunction

    // Running state entered when a command with a non-zero count is accepted
    function automatic seq_state_t op_to_state(input logic [1:0] op);
        case (op)
            OP_SET:    op_to_state = ST_SET_DWELL;
            OP_PUMP_A: op_to_state = ST_PUMP_A;
            OP_PUMP_B: op_to_state = ST_PUMP_B;
            OP_FLUSH:  op_to_state = ST_FLUSH;
            default:   op_to_state = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/multi_device_valve_sequencer_phase_timer.sv
// Phase prescaler: while run is high, counts 0..PHASE_TICKS-1 and flags the
// last tick of each phase on phase_end (combinational strobe).
// Ports: clk, rst (async active-high), clear (sync restart), run (count
// enable), phase_end (high on the final tick of a phase).
module multi_device_valve_sequencer_phase_timer #(
    parameter int PHASE_TICKS = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic phase_end
);
    import multi_device_valve_sequencer_pkg::*;

    localparam int TICK_W = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PHASE_TICKS - 1);

    logic [TICK_W-1:0] tick_r;

    // Tick counter: restarts on clear, wraps at the end of every phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_r <= '0;
        end else if (clear) begin
            tick_r <= '0;
        end else if (run) begin
            if (tick_r == TICK_LAST) begin
                tick_r <= '0;
            end else begin
                tick_r <= tick_r + TICK_W'(1);
            end
        end else begin
            tick_r <= tick_r;
        end
    end

    assign phase_end = run && !clear && (tick_r == TICK_LAST);

endmodule

// File: rtl/multi_device_valve_sequencer.sv
// Valve sequencer driving the shared control, pump and flush lines of a pad
// wrapper hosting NUM_DEVICES microfluidic devices.
// Ports: clk/rst (async active-high); command interface cmd_valid/cmd_ready,
// cmd_op, cmd_count, cmd_ctrl_a, cmd_ctrl_s, cmd_dev_mask; abort; registered
// outputs ctrl_a, ctrl_s, pump_a, pump_b, flush, dev_en, busy, done.
module multi_device_valve_sequencer #(
    parameter int NUM_DEVICES  = 2,
    parameter int CTRL_A_WIDTH = 13,
    parameter int CTRL_S_WIDTH = 4,
    parameter int FLUSH_SIZE   = 21,
    parameter int PHASE_TICKS  = 1024,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [COUNT_WIDTH-1:0]  cmd_count,
    input  logic [CTRL_A_WIDTH-1:0] cmd_ctrl_a,
    input  logic [CTRL_S_WIDTH-1:0] cmd_ctrl_s,
    input  logic [NUM_DEVICES-1:0]  cmd_dev_mask,
    input  logic                    abort,
    output logic [CTRL_A_WIDTH-1:0] ctrl_a,
    output logic [CTRL_S_WIDTH-1:0] ctrl_s,
    output logic [2:0]              pump_a,
    output logic [1:0]              pump_b,
    output logic [FLUSH_SIZE-1:0]   flush,
    output logic [NUM_DEVICES-1:0]  dev_en,
    output logic                    busy,
    output logic                    done
);
    import multi_device_valve_sequencer_pkg::*;

    localparam int FIDX_W = (FLUSH_SIZE > 1) ? $clog2(FLUSH_SIZE) : 1;
    localparam logic [FIDX_W-1:0]     FIDX_LAST = FIDX_W'(FLUSH_SIZE - 1);
    localparam logic [FLUSH_SIZE-1:0] FLUSH_ONE = FLUSH_SIZE'(1);

    seq_state_t              state_r, state_s;
    logic [COUNT_WIDTH-1:0]  count_r, count_s, cnt_r, cnt_s, last_cnt_s;
    logic [2:0]              phase_r, phase_s;
    logic [FIDX_W-1:0]       fidx_r, fidx_s;
    logic [CTRL_A_WIDTH-1:0] ctrl_a_r, ctrl_a_s;
    logic [CTRL_S_WIDTH-1:0] ctrl_s_r, ctrl_s_s;
    logic [NUM_DEVICES-1:0]  dev_en_r, dev_en_s;
    logic [2:0]              pump_a_r, pump_a_s;
    logic [1:0]              pump_b_r, pump_b_s;
    logic [FLUSH_SIZE-1:0]   flush_r, flush_s;
    logic                    busy_r, done_r, done_s, ready_r;
    logic                    accept_s, kill_s, finish_s, phase_end_s;

    // abort with cmd_valid in the same cycle blocks acceptance
    assign accept_s   = cmd_valid && ready_r && !abort && (state_r == ST_IDLE);
    assign kill_s     = abort && (state_r != ST_IDLE);
    // count_r is never 0 while running, so this cannot underflow when used
    assign last_cnt_s = count_r - COUNT_WIDTH'(1);

    multi_device_valve_sequencer_phase_timer #(
        .PHASE_TICKS (PHASE_TICKS)
    ) u_phase_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept_s || kill_s),
        .run       (state_r != ST_IDLE),
        .phase_end (phase_end_s)
    );

    // Next-state, counter and output computation
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        cnt_s    = cnt_r;
        phase_s  = phase_r;
        fidx_s   = fidx_r;
        ctrl_a_s = ctrl_a_r;
        ctrl_s_s = ctrl_s_r;
        dev_en_s = dev_en_r;
        done_s   = 1'b0;
        finish_s = 1'b0;

        if (state_r == ST_IDLE) begin
            if (accept_s) begin
                count_s  = cmd_count;
                dev_en_s = cmd_dev_mask;
                cnt_s    = '0;
                phase_s  = 3'd0;
                fidx_s   = '0;
                if (cmd_op == OP_SET) begin
                    ctrl_a_s = cmd_ctrl_a;
                    ctrl_s_s = cmd_ctrl_s;
                end else begin
                    ctrl_a_s = ctrl_a_r;
                    ctrl_s_s = ctrl_s_r;
                end
                // A zero count completes immediately without running a phase
                if (cmd_count == '0) begin
                    done_s = 1'b1;
                end else begin
                    state_s = op_to_state(cmd_op);
                end
            end else begin
                state_s = ST_IDLE;
            end
        end else if (abort) begin
            state_s  = ST_IDLE;
            dev_en_s = '0;
            cnt_s    = '0;
            phase_s  = 3'd0;
            fidx_s   = '0;
        end else if (phase_end_s) begin
            case (state_r)
                ST_SET_DWELL: begin
                    if (cnt_r == last_cnt_s) begin
                        finish_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + COUNT_WIDTH'(1);
                    end
                end
                ST_PUMP_A, ST_PUMP_B: begin
                    if (phase_r == ((state_r == ST_PUMP_A) ? PUMP_A_LAST : PUMP_B_LAST)) begin
                        if (cnt_r == last_cnt_s) begin
                            finish_s = 1'b1;
                        end else begin
                            phase_s = 3'd0;
                            cnt_s   = cnt_r + COUNT_WIDTH'(1);
                        end
                    end else begin
                        phase_s = phase_r + 3'd1;
                    end
                end
                ST_FLUSH: begin
                    // cnt_r counts phases spent on the current hole
                    if (cnt_r == last_cnt_s) begin
                        cnt_s = '0;
                        if (fidx_r == FIDX_LAST) begin
                            finish_s = 1'b1;
                        end else begin
                            fidx_s = fidx_r + FIDX_W'(1);
                        end
                    end else begin
                        cnt_s = cnt_r + COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        if (finish_s) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
            cnt_s   = '0;
            phase_s = 3'd0;
            fidx_s  = '0;
        end else begin
            done_s = done_s;
        end

        // Sequence outputs follow the next state so they register with it
        pump_a_s = (state_s == ST_PUMP_A) ? pump_a_pattern(phase_s) : 3'b000;
        pump_b_s = (state_s == ST_PUMP_B) ? pump_b_pattern(phase_s) : 2'b00;
        flush_s  = (state_s == ST_FLUSH) ? (FLUSH_ONE << fidx_s) : '0;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            count_r  <= '0;
            cnt_r    <= '0;
            phase_r  <= 3'd0;
            fidx_r   <= '0;
            ctrl_a_r <= '0;
            ctrl_s_r <= '0;
            dev_en_r <= '0;
            pump_a_r <= 3'b000;
            pump_b_r <= 2'b00;
            flush_r  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            cnt_r    <= cnt_s;
            phase_r  <= phase_s;
            fidx_r   <= fidx_s;
            ctrl_a_r <= ctrl_a_s;
            ctrl_s_r <= ctrl_s_s;
            dev_en_r <= dev_en_s;
            pump_a_r <= pump_a_s;
            pump_b_r <= pump_b_s;
            flush_r  <= flush_s;
            busy_r   <= (state_s != ST_IDLE);
            done_r   <= done_s;
            ready_r  <= (state_s == ST_IDLE);
        end
    end

    assign cmd_ready = ready_r;
    assign ctrl_a    = ctrl_a_r;
    assign ctrl_s    = ctrl_s_r;
    assign pump_a    = pump_a_r;
    assign pump_b    = pump_b_r;
    assign flush     = flush_r;
    assign dev_en    = dev_en_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_multi_device_valve_sequencer.sv
// Directed bench for multi_device_valve_sequencer with PHASE_TICKS=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_device_valve_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_count;
    logic [12:0] cmd_ctrl_a;
    logic [3:0]  cmd_ctrl_s;
    logic [1:0]  cmd_dev_mask;
    logic        abort;
    logic [12:0] ctrl_a;
    logic [3:0]  ctrl_s;
    logic [2:0]  pump_a;
    logic [1:0]  pump_b;
    logic [20:0] flush;
    logic [1:0]  dev_en;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    multi_device_valve_sequencer #(
        .NUM_DEVICES  (2),
        .CTRL_A_WIDTH (13),
        .CTRL_S_WIDTH (4),
        .FLUSH_SIZE   (21),
        .PHASE_TICKS  (4),
        .COUNT_WIDTH  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_count    (cmd_count),
        .cmd_ctrl_a   (cmd_ctrl_a),
        .cmd_ctrl_s   (cmd_ctrl_s),
        .cmd_dev_mask (cmd_dev_mask),
        .abort        (abort),
        .ctrl_a       (ctrl_a),
        .ctrl_s       (ctrl_s),
        .pump_a       (pump_a),
        .pump_b       (pump_b),
        .flush        (flush),
        .dev_en       (dev_en),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  count;
        logic [12:0] ca;
        logic [3:0]  cs;
        logic [1:0]  mask;
        int          lat;
        logic [12:0] exp_ca;
        logic [3:0]  exp_cs;
    } vec_t;

    vec_t vecs [8];
    logic [2:0] pa_exp [6];
    logic [1:0] pb_exp [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one command during cycle t; returns at the sample point of t+1
    task automatic send(input logic [1:0] op, input logic [7:0] cnt, input logic [12:0] ca,
                        input logic [3:0] cs, input logic [1:0] m);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
        cmd_ctrl_a = ca; cmd_ctrl_s = cs; cmd_dev_mask = m;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Advances until done, starting at cycle index start; bounded
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (done !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;

        pa_exp = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        pb_exp = '{2'b10, 2'b11, 2'b01, 2'b00};
        //         op    count ca       cs    mask  lat  exp_ca   exp_cs
        vecs[0] = '{2'd0, 8'd3, 13'h1A5, 4'h9, 2'b10, 13,  13'h1A5, 4'h9};
        vecs[1] = '{2'd1, 8'd2, 13'h000, 4'h0, 2'b01, 49,  13'h1A5, 4'h9};
        vecs[2] = '{2'd2, 8'd1, 13'h0FF, 4'h1, 2'b11, 17,  13'h1A5, 4'h9};
        vecs[3] = '{2'd3, 8'd1, 13'h000, 4'h0, 2'b10, 85,  13'h1A5, 4'h9};
        vecs[4] = '{2'd2, 8'd0, 13'h000, 4'h0, 2'b01, 1,   13'h1A5, 4'h9};
        vecs[5] = '{2'd0, 8'd0, 13'h0F0, 4'h3, 2'b11, 1,   13'h0F0, 4'h3};
        vecs[6] = '{2'd3, 8'd2, 13'h000, 4'h0, 2'b01, 169, 13'h0F0, 4'h3};
        vecs[7] = '{2'd0, 8'd1, 13'h1FFF, 4'hF, 2'b01, 5,  13'h1FFF, 4'hF};

        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = 8'd0;
        cmd_ctrl_a = 13'h0; cmd_ctrl_s = 4'h0; cmd_dev_mask = 2'b00; abort = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_outs", {ctrl_a, ctrl_s, pump_a, pump_b, flush, dev_en, done}, 0);
        rst = 1'b0;

        // Table: latency to done and persistent state afterwards
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].op, vecs[i].count, vecs[i].ca, vecs[i].cs, vecs[i].mask);
            if (vecs[i].count != 8'd0) begin
                check($sformatf("v%0d_busy_t1", i), {busy, cmd_ready}, 2'b10);
            end
            check($sformatf("v%0d_dev_en", i), dev_en, vecs[i].mask);
            wait_done(1, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_idle", i), {busy, cmd_ready, pump_a, pump_b, flush}, {2'b01, 26'h0});
            check($sformatf("v%0d_ctrl", i), {ctrl_a, ctrl_s}, {vecs[i].exp_ca, vecs[i].exp_cs});
            check($sformatf("v%0d_dev_hold", i), dev_en, vecs[i].mask);
        end

        // PUMP_A waveform, two full cycles
        send(2'd1, 8'd2, 13'h0, 4'h0, 2'b11);
        for (int k = 1; k <= 48; k++) begin
            check($sformatf("pa_k%0d", k), {pump_a, done}, {pa_exp[((k - 1) / 4) % 6], 1'b0});
            @(negedge clk);
        end
        check("pa_done", {done, pump_a}, 4'b1000);
        @(negedge clk);
        check("pa_done_pulse", done, 0);

        // FLUSH one-hot walk
        send(2'd3, 8'd1, 13'h0, 4'h0, 2'b01);
        for (int k = 1; k <= 84; k++) begin
            check($sformatf("fl_k%0d", k), flush, 32'd1 << ((k - 1) / 4));
            @(negedge clk);
        end
        check("fl_done", {done, 21'(flush)}, {1'b1, 21'h0});

        // PUMP_B abort during cycle t+7
        send(2'd2, 8'd5, 13'h0, 4'h0, 2'b11);
        repeat (6) @(negedge clk);
        check("ab_pre", pump_b, 2'b11);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_outs", {pump_b, dev_en, busy, cmd_ready, done}, 7'b0000010);
        check("ab_ctrl_held", ctrl_a, 13'h1FFF);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("ab_no_done", pulses, 0);

        // abort together with cmd_valid rejects the command
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_count = 8'd1; cmd_dev_mask = 2'b11; abort = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0;
        check("rej_state", {busy, cmd_ready, dev_en, pump_a}, 7'b0100000);

        // cmd_valid while busy is ignored
        send(2'd2, 8'd1, 13'h0, 4'h0, 2'b11);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_count = 8'd0; cmd_ctrl_a = 13'h555; cmd_dev_mask = 2'b01;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bz_pump", {pump_b, busy, cmd_ready}, 4'b1010);
        wait_done(3, lat);
        check("bz_latency", lat, 17);
        check("bz_ctrl", {ctrl_a, dev_en}, {13'h1FFF, 2'b11});

        // Asynchronous reset in the middle of PUMP_A
        send(2'd1, 8'd1, 13'h0, 4'h0, 2'b01);
        repeat (5) @(negedge clk);
        check("rs_pre", pump_a, 3'b110);
        #2 rst = 1'b1;
        #1;
        check("rs_async", {pump_a, dev_en, busy, ctrl_a, cmd_ready}, 20'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rs_release", {cmd_ready, busy, pump_a}, 5'b10000);
        send(2'd0, 8'd1, 13'h0AA, 4'h5, 2'b10);
        wait_done(1, lat);
        check("rs_recover", {lat[7:0], ctrl_a, ctrl_s}, {8'd5, 13'h0AA, 4'h5});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
